uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Packet-level far end of the UART byte link. Consumes received-byte strobes, parses
//  4-byte request packets (SYNC, CMD, ARG, CHK), executes PING/READ/WRITE on an 8-bit
//  scratch register, and drives a 4-byte reply into the UART transmit request port.
//  TX bytes are paced by a fixed gap because the UART transmitter has no busy flag.
// PARAMETERS
//  BYTE_CYCLES  224    clk cycles between successive tx_strobe pulses (>= UART TX frame of 221)
//  RX_TIMEOUT   2048   idle clk cycles inside a partial packet before it is discarded
//  SYNC         8'hAA  packet header byte, used in requests and replies
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst_n       in   1  asynchronous active-low reset
//  rx_data     in   8  received byte; valid in the rx_strobe cycle
//  rx_strobe   in   1  one-cycle pulse per received byte
//  tx_data     out  8  byte to transmit; held stable from its tx_strobe until the next tx_strobe
//  tx_strobe   out  1  one-cycle pulse requesting transmission of tx_data
//  busy        out  1  high from reply start until the post-reply gap ends
//  scratch     out  8  scratch register, written by the WRITE command
//  err_count   out  8  count of checksum failures and timeouts; saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HUNT, tx_data=0, tx_strobe=0, busy=0, scratch=0,
//    err_count=0, all counters 0. Reset mid-reply aborts the reply; no further strobes.
//  FSM states: HUNT, GET_CMD, GET_ARG, GET_CHK, REPLY, GAP.
//  HUNT: on rx_strobe with rx_data==SYNC -> GET_CMD. Any other byte is ignored.
//  GET_CMD / GET_ARG: latch the byte and advance.
//  GET_CHK: on a byte equal to CMD^ARG -> execute, then REPLY. On any other byte ->
//    err_count+1, then HUNT (no reply).
//  Timeout: in GET_*, an idle counter resets on each rx_strobe. At RX_TIMEOUT cycles without
//    a byte -> HUNT, err_count+1.
//  Commands and reply bytes [b0,b1,b2,b3]; b3 is always b1^b2:
//    0x01 PING   -> [SYNC, 0x81, ARG, chk]
//    0x02 READ   -> [SYNC, 0x82, scratch, chk]
//    0x03 WRITE  -> scratch<=ARG in the execute cycle, then [SYNC, 0x83, ARG, chk]
//    other       -> NAK [SYNC, 0xFF, CMD, chk]
//  Reply timing: busy rises and tx_strobe for b0 fires on the cycle after the valid-CHK
//    rx_strobe (latency 1). b1..b3 strobe at +BYTE_CYCLES, +2*, +3* cycles after b0.
//  GAP: after the b3 strobe, busy stays high for BYTE_CYCLES cycles, then -> HUNT with busy=0.
//  While REPLY/GAP, incoming rx_strobe bytes are dropped and not counted. The gap counter is
//    log2(BYTE_CYCLES)+1 bits wide. err_count must not wrap. A rx_strobe landing in the same
//    cycle that a timeout fires: the timeout wins and the byte is dropped.
// TESTING
//  1 PING: rx AA,01,5A,5B -> tx AA,81,5A,DB. First strobe 1 cycle after the 5B strobe;
//    strobes spaced exactly 224 cycles. busy falls 224 cycles after the last strobe.
//  2 WRITE then READ: AA,03,3C,3F -> AA,83,3C,BF and scratch=3C. After busy falls,
//    AA,02,00,02 -> AA,82,3C,BE.
//  3 Bad checksum: AA,01,5A,00 -> no tx_strobe, err_count 0->1. Next valid PING is answered.
//  4 Unknown command: AA,07,00,07 -> NAK AA,FF,07,F8. scratch unchanged.
//  5 Timeout/garbage: 12,AA,01 then 2048 idle cycles -> err_count+1, HUNT. A following PING
//    is answered. 300 checksum errors -> err_count=FF.
//  6 Reset mid-reply: assert rst_n=0 after the b1 strobe -> all outputs 0 immediately.
//    No b2/b3 strobes follow.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Packet-level far end of the UART byte link. Parses 4-byte requests
// (SYNC, CMD, ARG, CHK), runs PING/READ/WRITE against an 8-bit scratch
// register and paces a 4-byte reply out through the transmit request port.
// The transmitter has no busy flag, so reply bytes are spaced by a fixed
// BYTE_CYCLES gap, and one more gap is held after the last byte.

module uart_cmd_responder #(
    parameter int          BYTE_CYCLES = 224,
    parameter int          RX_TIMEOUT  = 2048,
    parameter logic [7:0]  SYNC        = 8'hAA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    output logic       busy,
    output logic [7:0] scratch,
    output logic [7:0] err_count
);

    localparam int GAP_W  = $clog2(BYTE_CYCLES) + 1;
    localparam int IDLE_W = $clog2(RX_TIMEOUT) + 1;

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(BYTE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] GET_CMD = 3'd1;
    localparam logic [2:0] GET_ARG = 3'd2;
    localparam logic [2:0] GET_CHK = 3'd3;
    localparam logic [2:0] REPLY   = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;

    logic [2:0]        state;
    logic [7:0]        cmdByte;
    logic [7:0]        argByte;
    logic [7:0]        replyCode;
    logic [7:0]        replyData;
    logic [1:0]        byteIdx;
    logic [GAP_W-1:0]  gapCnt;
    logic [IDLE_W-1:0] idleCnt;

    logic       inPacket;
    logic       timeoutHit;
    logic       chkOk;
    logic       errInc;
    logic [7:0] respCode;
    logic [7:0] respData;

    // Decode the latched command into the reply code/data pair and flag errors
    always_comb begin
        respCode   = 8'hFF;
        respData   = cmdByte;
        inPacket   = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
        timeoutHit = inPacket && (idleCnt == IDLE_LAST);
        chkOk      = (rx_data == (cmdByte ^ argByte));
        errInc     = timeoutHit ||
                     ((state == GET_CHK) && rx_strobe && !chkOk);
        case (cmdByte)
            8'h01: begin
                respCode = 8'h81;
                respData = argByte;
            end
            8'h02: begin
                respCode = 8'h82;
                respData = scratch;
            end
            8'h03: begin
                respCode = 8'h83;
                respData = argByte;
            end
            default: begin
                respCode = 8'hFF;
                respData = cmdByte;
            end
        endcase
    end

    // Saturating error counter for checksum failures and partial-packet timeouts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (errInc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

    // Packet parser, command execution and paced reply transmitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            cmdByte   <= 8'h00;
            argByte   <= 8'h00;
            replyCode <= 8'h00;
            replyData <= 8'h00;
            byteIdx   <= 2'd0;
            gapCnt    <= '0;
            idleCnt   <= '0;
            tx_data   <= 8'h00;
            tx_strobe <= 1'b0;
            busy      <= 1'b0;
            scratch   <= 8'h00;
        end else begin
            tx_strobe <= 1'b0;
            case (state)
                HUNT: begin
                    idleCnt <= '0;
                    if (rx_strobe && (rx_data == SYNC)) begin
                        state <= GET_CMD;
                    end
                end
                GET_CMD, GET_ARG, GET_CHK: begin
                    if (timeoutHit) begin
                        state   <= HUNT;
                        idleCnt <= '0;
                    end else if (rx_strobe) begin
                        idleCnt <= '0;
                        if (state == GET_CMD) begin
                            cmdByte <= rx_data;
                            state   <= GET_ARG;
                        end else if (state == GET_ARG) begin
                            argByte <= rx_data;
                            state   <= GET_CHK;
                        end else if (chkOk) begin
                            if (cmdByte == 8'h03) begin
                                scratch <= argByte;
                            end
                            replyCode <= respCode;
                            replyData <= respData;
                            tx_data   <= SYNC;
                            tx_strobe <= 1'b1;
                            busy      <= 1'b1;
                            byteIdx   <= 2'd1;
                            gapCnt    <= '0;
                            state     <= REPLY;
                        end else begin
                            state <= HUNT;
                        end
                    end else begin
                        idleCnt <= idleCnt + 1'b1;
                    end
                end
                REPLY: begin
                    if (gapCnt == GAP_LAST) begin
                        gapCnt    <= '0;
                        tx_strobe <= 1'b1;
                        byteIdx   <= byteIdx + 2'd1;
                        case (byteIdx)
                            2'd1:    tx_data <= replyCode;
                            2'd2:    tx_data <= replyData;
                            default: tx_data <= replyCode ^ replyData;
                        endcase
                        if (byteIdx == 2'd3) begin
                            state <= GAP;
                        end
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        gapCnt <= '0;
                        busy   <= 1'b0;
                        state  <= HUNT;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder
// Directed packets go in through applyStimulus, which queues the expected
// reply bytes together with the cycle each strobe should land on. A monitor
// pops the queue on every tx_strobe and compares byte and timing.

module tb_uart_cmd_responder;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       busy;
    logic [7:0] scratch;
    logic [7:0] err_count;

    exp_t expQ[$];
    exp_t monE;
    int   cycleCount;
    int   lastStrobeCycle;
    int   testsRun;
    int   failCount;

    uart_cmd_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .busy      (busy),
        .scratch   (scratch),
        .err_count (err_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp expected and observed strobes
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every tx_strobe must match the head of the queue
    always @(negedge clk) begin
        if (tx_strobe) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_strobe: got tx_data=%0h, expected no strobe", tx_data);
            end else begin
                monE = expQ.pop_front();
                checkOutput("tx_data", int'(tx_data), int'(monE.data));
                checkOutput("tx_cycle", cycleCount, monE.cycle);
            end
            lastStrobeCycle = cycleCount;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    // Send one packet; if a reply is expected, queue its bytes and strobe cycles
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] arg,
                                 input logic [7:0] chk, input bit expectReply,
                                 input logic [7:0] r1, input logic [7:0] r2,
                                 input logic [7:0] r3);
        int   c;
        exp_t e;
        sendByte(8'hAA);
        sendByte(cmd);
        sendByte(arg);
        @(posedge clk);
        #1;
        rx_data   = chk;
        rx_strobe = 1'b1;
        c = cycleCount + 1;
        if (expectReply) begin
            e.data = 8'hAA; e.cycle = c;       expQ.push_back(e);
            e.data = r1;    e.cycle = c + 224; expQ.push_back(e);
            e.data = r2;    e.cycle = c + 448; expQ.push_back(e);
            e.data = r3;    e.cycle = c + 672; expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    // Wait for the reply and post-reply gap to finish, optionally checking the gap length
    task automatic waitIdle(input bit checkGap);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!busy && expQ.size() == 0) break;
            n++;
        end
        if (n >= 3000) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL idle_timeout: busy=%0b queue=%0d, expected idle", busy, expQ.size());
        end else if (checkGap) begin
            checkOutput("busy_gap", cycleCount - lastStrobeCycle, 224);
        end
    endtask

    // Global watchdog
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        testsRun        = 0;
        failCount       = 0;
        cycleCount      = 0;
        lastStrobeCycle = 0;
        rx_data         = 8'h00;
        rx_strobe       = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx_strobe", int'(tx_strobe), 0);
        checkOutput("reset_tx_data", int'(tx_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_scratch", int'(scratch), 0);
        checkOutput("reset_err", int'(err_count), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] test 1: PING");
        applyStimulus(8'h01, 8'h5A, 8'h5B, 1'b1, 8'h81, 8'h5A, 8'hDB);
        checkOutput("busy_rise", int'(busy), 1);
        sendByte(8'hAA);
        sendByte(8'h01);
        sendByte(8'h11);
        sendByte(8'h10);
        waitIdle(1'b1);

        $display("[TB] test 2: WRITE then READ");
        applyStimulus(8'h03, 8'h3C, 8'h3F, 1'b1, 8'h83, 8'h3C, 8'hBF);
        waitIdle(1'b1);
        checkOutput("scratch_write", int'(scratch), 32'h3C);
        applyStimulus(8'h02, 8'h00, 8'h02, 1'b1, 8'h82, 8'h3C, 8'hBE);
        waitIdle(1'b1);

        $display("[TB] test 3: bad checksum");
        applyStimulus(8'h01, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("err_badchk", int'(err_count), 1);
        checkOutput("busy_badchk", int'(busy), 0);
        applyStimulus(8'h01, 8'h77, 8'h76, 1'b1, 8'h81, 8'h77, 8'hF6);
        waitIdle(1'b1);

        $display("[TB] test 4: unknown command");
        applyStimulus(8'h07, 8'h00, 8'h07, 1'b1, 8'hFF, 8'h07, 8'hF8);
        waitIdle(1'b1);
        checkOutput("scratch_nak", int'(scratch), 32'h3C);

        $display("[TB] test 5: garbage and timeout");
        sendByte(8'h12);
        sendByte(8'hAA);
        sendByte(8'h01);
        repeat (1000) @(posedge clk);
        #1;
        checkOutput("err_before_timeout", int'(err_count), 1);
        repeat (1100) @(posedge clk);
        #1;
        checkOutput("err_timeout", int'(err_count), 2);
        applyStimulus(8'h01, 8'hC3, 8'hC2, 1'b1, 8'h81, 8'hC3, 8'h42);
        waitIdle(1'b1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'h01, 8'h00, 8'h55, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_saturate", int'(err_count), 32'hFF);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("[TB] test 6: reset mid-reply");
        applyStimulus(8'h01, 8'h22, 8'h23, 1'b1, 8'h81, 8'h22, 8'hA3);
        n = 0;
        while (n < 1000 && expQ.size() > 2) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b1_seen", expQ.size(), 2);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("rst_tx_strobe", int'(tx_strobe), 0);
        checkOutput("rst_tx_data", int'(tx_data), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_scratch", int'(scratch), 0);
        checkOutput("rst_err", int'(err_count), 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
